// File: rtl/disaster_alarm_sequencer.sv
// Hazard persistence filter, sticky latch, blinking siren and ack/clear FSM.
// Optional ALARM_ESCALATE_EN adds the unacknowledged-alarm escalation flag.
module disaster_alarm_sequencer #(
  parameter int PERSIST    = 4,
  parameter int BLINK_DIV  = 8,
  parameter int ESC_LIMIT  = 64,
  parameter int CLEAR_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flood_in,
  input  logic       cyclone_in,
  input  logic       earthquake_in,
  input  logic       tsunami_in,
  input  logic       ack,
  output logic [3:0] latched,
  output logic [1:0] active_code,
  output logic       active_valid,
  output logic       siren,
  output logic       escalate,
  output logic [1:0] state
);

  localparam int PW = $clog2(PERSIST + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int CW = $clog2(CLEAR_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    ALARM   = 2'd2,
    ACKED   = 2'd3
  } st_e;

  st_e           st_q, st_d;
  logic [3:0]    ev, fresh;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    lat_q, lat_d;
  logic [PW-1:0] pcnt_q, pcnt_d, p_inc;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d, c_inc;
  logic          siren_q, siren_d;
  logic          go_alarm;
  logic          esc_rst, esc_clr, esc_run;

  assign ev    = {tsunami_in, earthquake_in, cyclone_in, flood_in};
  assign fresh = ev & ~lat_q;
  assign p_inc = (pcnt_q == PW'(PERSIST)) ? pcnt_q : pcnt_q + 1'b1;
  assign c_inc = (ccnt_q == CW'(CLEAR_HOLD)) ? ccnt_q : ccnt_q + 1'b1;

  always_comb begin
    st_d     = st_q;
    cand_d   = cand_q;
    pcnt_d   = pcnt_q;
    lat_d    = lat_q;
    bcnt_d   = bcnt_q;
    ccnt_d   = ccnt_q;
    siren_d  = siren_q;
    go_alarm = 1'b0;
    esc_rst  = 1'b0;
    esc_clr  = 1'b0;
    esc_run  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (|ev) begin
          st_d     = CONFIRM;
          cand_d   = ev;
          pcnt_d   = PW'(1);
          go_alarm = (PERSIST <= 1);
        end
      end
      CONFIRM: begin
        if (ev == 4'd0) begin
          st_d   = IDLE;
          cand_d = '0;
          pcnt_d = '0;
        end else if (ev != cand_q) begin
          cand_d   = ev;
          pcnt_d   = PW'(1);
          go_alarm = (PERSIST <= 1);
        end else begin
          pcnt_d   = p_inc;
          go_alarm = (p_inc == PW'(PERSIST));
        end
      end
      ALARM: begin
        lat_d = lat_q | ev;
        if (ack && fresh == 4'd0) begin
          st_d    = ACKED;
          siren_d = 1'b0;
          bcnt_d  = '0;
          ccnt_d  = '0;
          esc_clr = 1'b1;
        end else begin
          esc_run = 1'b1;
          if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            siren_d = ~siren_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ACKED: begin
        if (fresh != 4'd0) begin
          st_d    = ALARM;
          lat_d   = lat_q | ev;
          siren_d = 1'b1;
          bcnt_d  = '0;
          ccnt_d  = '0;
          esc_rst = 1'b1;
        end else if (ev != 4'd0) begin
          ccnt_d = '0;
        end else if (c_inc == CW'(CLEAR_HOLD)) begin
          st_d   = IDLE;
          lat_d  = '0;
          ccnt_d = '0;
        end else begin
          ccnt_d = c_inc;
        end
      end
      default: st_d = IDLE;
    endcase
    // confirmed candidate enters ALARM on this same edge
    if (go_alarm) begin
      st_d    = ALARM;
      lat_d   = cand_d;
      cand_d  = '0;
      pcnt_d  = '0;
      siren_d = 1'b1;
      bcnt_d  = '0;
      esc_rst = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cand_q  <= '0;
      lat_q   <= '0;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      ccnt_q  <= '0;
      siren_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cand_q  <= cand_d;
      lat_q   <= lat_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      ccnt_q  <= ccnt_d;
      siren_q <= siren_d;
    end
  end

`ifdef ALARM_ESCALATE_EN
  localparam int EW = $clog2(ESC_LIMIT + 1);

  logic [EW-1:0] ecnt_q, e_inc;
  logic          esc_q;

  assign e_inc = (ecnt_q == EW'(ESC_LIMIT)) ? ecnt_q : ecnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q <= '0;
      esc_q  <= 1'b0;
    end else if (esc_clr) begin
      ecnt_q <= '0;
      esc_q  <= 1'b0;
    end else if (esc_rst) begin
      ecnt_q <= '0;
    end else if (esc_run) begin
      ecnt_q <= e_inc;
      if (e_inc == EW'(ESC_LIMIT)) esc_q <= 1'b1;
    end
  end

  assign escalate = esc_q;
`else
  logic unused_esc;
  assign unused_esc = esc_rst | esc_clr | esc_run;
  assign escalate   = 1'b0;
`endif

  always_comb begin
    if (lat_q[3])      active_code = 2'd3;
    else if (lat_q[2]) active_code = 2'd2;
    else if (lat_q[1]) active_code = 2'd1;
    else               active_code = 2'd0;
  end

  assign latched      = lat_q;
  assign active_valid = |lat_q;
  assign siren        = siren_q;
  assign state        = st_q;

endmodule

// File: tb/tb_disaster_alarm_sequencer.sv
// Randomized + directed bench for disaster_alarm_sequencer against an
// event-history reference model.
module tb_disaster_alarm_sequencer;

  localparam int PERSIST    = 4;
  localparam int BLINK_DIV  = 8;
  localparam int ESC_LIMIT  = 64;
  localparam int CLEAR_HOLD = 16;
`ifdef ALARM_ESCALATE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flood_in = 1'b0;
  logic       cyclone_in = 1'b0;
  logic       earthquake_in = 1'b0;
  logic       tsunami_in = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] latched;
  logic [1:0] active_code;
  logic       active_valid;
  logic       siren;
  logic       escalate;
  logic [1:0] state;

  int total = 0;
  int bad = 0;

  disaster_alarm_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .flood_in(flood_in), .cyclone_in(cyclone_in),
    .earthquake_in(earthquake_in), .tsunami_in(tsunami_in),
    .ack(ack), .latched(latched), .active_code(active_code),
    .active_valid(active_valid), .siren(siren),
    .escalate(escalate), .state(state)
  );

  always #5 clk = ~clk;

  // Reference: mode 0 idle, 1 confirming, 2 alarm, 3 acked.
  // Siren and escalation derive from the age of the current alarm.
  int         m_st = 0;
  int         m_run = 0;
  int         m_age = 0;
  int         m_ua = 0;
  int         m_clr = 0;
  logic [3:0] m_cand = 4'd0;
  logic [3:0] m_lat = 4'd0;
  bit         m_esc = 1'b0;
  logic [3:0] m_e, m_nb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_run = 0; m_age = 0; m_ua = 0; m_clr = 0;
      m_cand = 4'd0; m_lat = 4'd0; m_esc = 1'b0;
    end else begin
      m_e = {tsunami_in, earthquake_in, cyclone_in, flood_in};
      m_nb = m_e & ~m_lat;
      case (m_st)
        0: if (m_e != 0) begin
          m_st = 1; m_cand = m_e; m_run = 1;
        end
        1: if (m_e == 0) begin
          m_st = 0; m_run = 0;
        end else if (m_e != m_cand) begin
          m_cand = m_e; m_run = 1;
        end else begin
          m_run++;
        end
        2: begin
          m_lat = m_lat | m_e;
          if (ack && m_nb == 0) begin
            m_st = 3; m_clr = 0; m_esc = 1'b0;
          end else begin
            m_age++; m_ua++;
            if (m_ua >= ESC_LIMIT) m_esc = ESC_EN;
          end
        end
        default: begin
          if (m_nb != 0) begin
            m_st = 2; m_lat = m_lat | m_e; m_age = 0; m_ua = 0;
          end else if (m_e != 0) begin
            m_clr = 0;
          end else begin
            m_clr++;
            if (m_clr >= CLEAR_HOLD) begin
              m_st = 0; m_lat = 4'd0; m_clr = 0;
            end
          end
        end
      endcase
      if (m_st == 1 && m_run >= PERSIST) begin
        m_st = 2; m_lat = m_cand; m_age = 0; m_ua = 0; m_run = 0;
      end
    end
  end

  function automatic int exp_code(input logic [3:0] l);
    if (l[3]) return 3;
    if (l[2]) return 2;
    if (l[1]) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int sir;
    sir = (m_st == 2 && ((m_age / BLINK_DIV) % 2 == 0)) ? 1 : 0;
    chk("m_state", int'(state), m_st);
    chk("m_latched", int'(latched), int'(m_lat));
    chk("m_code", int'(active_code), exp_code(m_lat));
    chk("m_valid", int'(active_valid), int'(m_lat != 0));
    chk("m_siren", int'(siren), sir);
    chk("m_escalate", int'(escalate), int'(m_esc));
  endtask

  // drive at negedge, let one posedge pass, compare at next negedge
  task automatic cyc(input logic [3:0] e, input logic a);
    {tsunami_in, earthquake_in, cyclone_in, flood_in} = e;
    ack = a;
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input logic [3:0] e, input int n);
    for (int i = 0; i < n; i++) cyc(e, 1'b0);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_latched", int'(latched), 0);
    chk("rst_out", int'({active_code, active_valid, siren, escalate}), 0);
    @(negedge clk);
    {tsunami_in, earthquake_in, cyclone_in, flood_in} = 4'd0;
    ack = 1'b0;
    rst_n = 1'b1;
  endtask

  logic [3:0] e, last;
  int r, len;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_outs", int'({latched, active_code, active_valid,
                            siren, escalate}), 0);
    rst_n = 1'b1;

    run(4'b0001, 3);
    cyc(4'b0000, 1'b0);
    chk("flood3_state", int'(state), 0);
    chk("flood3_lat", int'(latched), 0);
    chk("flood3_siren", int'(siren), 0);

    run(4'b0010, 4);
    chk("cyc4_state", int'(state), 2);
    chk("cyc4_lat", int'(latched), 4'b0010);
    chk("cyc4_code", int'(active_code), 1);
    chk("cyc4_siren", int'(siren), 1);
    run(4'b0000, 7);
    chk("blink_7", int'(siren), 1);
    run(4'b0000, 1);
    chk("blink_8", int'(siren), 0);
    run(4'b0000, 8);
    chk("blink_16", int'(siren), 1);

    cyc(4'b0000, 1'b1);
    chk("ack_state", int'(state), 3);
    chk("ack_siren", int'(siren), 0);
    run(4'b0000, 15);
    chk("clr15_state", int'(state), 3);
    run(4'b0000, 1);
    chk("clr16_state", int'(state), 0);
    chk("clr16_lat", int'(latched), 0);

    run(4'b0010, 4);
    cyc(4'b0000, 1'b1);
    cyc(4'b1000, 1'b0);
    chk("tsu_state", int'(state), 2);
    chk("tsu_lat", int'(latched), 4'b1010);
    chk("tsu_code", int'(active_code), 3);

    cyc(4'b0100, 1'b1);
    chk("ackrace_state", int'(state), 2);
    chk("ackrace_lat", int'(latched), 4'b1110);

    run(4'b0000, 10);
    chk("esc_early", int'(escalate), 0);
    run(4'b0000, 60);
    chk("esc_late", int'(escalate), int'(ESC_EN));
    cyc(4'b0000, 1'b1);
    chk("esc_ack", int'(escalate), 0);
    chk("esc_ack_state", int'(state), 3);

    run(4'b0000, 16);
    run(4'b0110, 4);
    chk("eqcy_lat", int'(latched), 4'b0110);
    mid_reset();
    @(negedge clk);
    compare_all();

    last = 4'd0;
    for (int b = 0; b < 600; b++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        e = 4'd0;
        len = $urandom_range(1, 20);
      end else begin
        e = (r < 6) ? last : 4'($urandom_range(1, 15));
        len = $urandom_range(1, 7);
      end
      last = e;
      for (int i = 0; i < len; i++)
        cyc(e, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
